// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: address width, instruction size,
// major opcodes and the fetch sequencer state encoding.
package riscv_pkg;

  localparam int ADDR_W     = 8;
  localparam int INSN_BYTES = 4;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pc_track_pipe.sv
// Two-slot valid/PC shift register that mirrors the ROM's two register
// stages, so the PC and validity of each ROM output word travel with it.
module pc_track_pipe
  import riscv_pkg::*;
#(
  parameter int PC_W = riscv_pkg::ADDR_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_i,
  input  logic [PC_W-1:0] issue_pc_i,
  input  logic            flush_i,
  output logic            valid_o,
  output logic [PC_W-1:0] pc_o
);

  logic            v1_q;
  logic            v2_q;
  logic [PC_W-1:0] pc1_q;
  logic [PC_W-1:0] pc2_q;

  // Shift issue/PC down both slots; a flush squashes whatever is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      pc1_q <= '0;
      pc2_q <= '0;
    end else begin
      v1_q  <= issue_i & ~flush_i;
      pc1_q <= issue_pc_i;
      v2_q  <= v1_q & ~flush_i;
      pc2_q <= pc1_q;
    end
  end

  assign valid_o = v2_q;
  assign pc_o    = pc2_q;

endmodule

// File: rtl/pc_fetch.sv
// Program counter and fetch sequencer in front of the instruction ROM.
// Drives the ROM address, qualifies ROM output words, applies stalls and
// taken-branch redirects, and halts at end of program or on a bad target.
module pc_fetch
  import riscv_pkg::*;
#(
  parameter int ADDR_W   = riscv_pkg::ADDR_W,
  parameter int RESET_PC = 4,
  parameter int END_ADDR = 252,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              halt,
  input  logic              branch_taken,
  input  logic [11:0]       branch_imm,
  output logic [ADDR_W-1:0] address,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic              err_misalign,
  output logic [CNT_W-1:0]  instr_count
);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] address_q;
  logic              halted_q;
  logic              err_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  logic              running;
  logic              redirect;
  logic              issue;
  logic [ADDR_W-1:0] branchOffset;
  logic [ADDR_W-1:0] target;
  logic              targetAligned;

  // Branch target: B-type offset is the immediate times two, sign-extended
  // (or truncated) to the address width so the sum wraps naturally.
  assign running       = (state_q == RUN);
  assign redirect      = instr_valid & branch_taken & running;
  assign issue         = running & ~redirect & ~halt & ~stall;
  assign branchOffset  = ADDR_W'($signed({branch_imm, 1'b0}));
  assign target        = pc_out + branchOffset;
  assign targetAligned = (target[1:0] == 2'b00);

  // Fetch FSM: redirect beats halt, halt beats stall, stall beats advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      address_q <= ADDR_W'(RESET_PC);
      halted_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      halted_q <= (state_q == HALT);
      case (state_q)
        RUN: begin
          if (redirect) begin
            if (targetAligned) begin
              address_q <= target;
            end else begin
              err_q   <= 1'b1;
              state_q <= HALT;
            end
          end else if (halt) begin
            state_q <= HALT;
          end else if (!stall) begin
            if (address_q == ADDR_W'(END_ADDR)) begin
              state_q <= HALT;
            end else begin
              address_q <= address_q + ADDR_W'(INSN_BYTES);
            end
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= HALT;
        end
      endcase
    end
  end

  // Retired-instruction count: a valid word the downstream accepts (not
  // stalled) retires, including a taken branch itself; saturates at all-ones.
  always_comb begin
    count_d = count_q;
    if (instr_valid && !stall && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  pc_track_pipe #(
    .PC_W (ADDR_W)
  ) u_track (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_i    (issue),
    .issue_pc_i (address_q),
    .flush_i    (redirect),
    .valid_o    (instr_valid),
    .pc_o       (pc_out)
  );

  assign address      = address_q;
  assign halted       = halted_q;
  assign err_misalign = err_q;
  assign instr_count  = count_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: reset values, sequential fetch, stalls,
// forward/backward/wrapping branches, misaligned target, end of program
// and asynchronous reset.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        branch_taken = 1'b0;
  logic [11:0] branch_imm = 12'd0;
  logic [7:0]  address;
  logic        instr_valid;
  logic [7:0]  pc_out;
  logic        halted;
  logic        err_misalign;
  logic [15:0] instr_count;

  int checks = 0;
  int failures = 0;

  pc_fetch #(
    .ADDR_W   (8),
    .RESET_PC (4),
    .END_ADDR (252),
    .CNT_W    (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .halt         (halt),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .address      (address),
    .instr_valid  (instr_valid),
    .pc_out       (pc_out),
    .halted       (halted),
    .err_misalign (err_misalign),
    .instr_count  (instr_count)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic h, input logic bt, input logic [11:0] imm);
    stall        = s;
    halt         = h;
    branch_taken = bt;
    branch_imm   = imm;
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic stepEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset, then release just after an edge so the next edge is edge 1.
  task automatic resetDut();
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // ---------------- Reset values and sequential fetch ----------------
    resetDut();
    checkOutput("rst_address", 32'(address), 32'd4);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_pc_out", 32'(pc_out), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_err", 32'(err_misalign), 32'd0);
    checkOutput("rst_count", 32'(instr_count), 32'd0);

    stepEdges(1);
    checkOutput("e1_address", 32'(address), 32'd8);
    checkOutput("e1_valid", 32'(instr_valid), 32'd0);
    stepEdges(1);
    checkOutput("e2_address", 32'(address), 32'd12);
    checkOutput("e2_valid", 32'(instr_valid), 32'd1);
    checkOutput("e2_pc_out", 32'(pc_out), 32'd4);
    checkOutput("e2_count", 32'(instr_count), 32'd0);
    stepEdges(1);
    checkOutput("e3_pc_out", 32'(pc_out), 32'd8);
    checkOutput("e3_count", 32'(instr_count), 32'd1);
    stepEdges(1);
    checkOutput("e4_address", 32'(address), 32'd20);
    checkOutput("e4_pc_out", 32'(pc_out), 32'd12);

    // ---------------- Stall three cycles at address 20 ----------------
    applyStimulus(1'b1, 1'b0, 1'b0, 12'd0);
    stepEdges(1);
    checkOutput("stall_e5_address", 32'(address), 32'd20);
    checkOutput("stall_e5_valid", 32'(instr_valid), 32'd1);
    checkOutput("stall_e5_pc_out", 32'(pc_out), 32'd16);
    checkOutput("stall_e5_count", 32'(instr_count), 32'd2);
    stepEdges(2);
    checkOutput("stall_e7_address", 32'(address), 32'd20);
    checkOutput("stall_e7_valid", 32'(instr_valid), 32'd0);
    checkOutput("stall_e7_count", 32'(instr_count), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    stepEdges(1);
    checkOutput("stall_e8_valid", 32'(instr_valid), 32'd0);
    checkOutput("stall_e8_address", 32'(address), 32'd24);
    stepEdges(1);
    checkOutput("stall_e9_valid", 32'(instr_valid), 32'd1);
    checkOutput("stall_e9_pc_out", 32'(pc_out), 32'd20);
    checkOutput("stall_e9_count", 32'(instr_count), 32'd2);

    // ---------------- Forward branch at pc 92, imm 6 -> 104 ----------------
    resetDut();
    stepEdges(24);
    checkOutput("fwd_pre_pc_out", 32'(pc_out), 32'd92);
    checkOutput("fwd_pre_count", 32'(instr_count), 32'd22);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd6);
    stepEdges(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("fwd_address", 32'(address), 32'd104);
    checkOutput("fwd_bubble1", 32'(instr_valid), 32'd0);
    checkOutput("fwd_count_branch", 32'(instr_count), 32'd23);
    stepEdges(1);
    checkOutput("fwd_bubble2", 32'(instr_valid), 32'd0);
    stepEdges(1);
    checkOutput("fwd_target_valid", 32'(instr_valid), 32'd1);
    checkOutput("fwd_target_pc", 32'(pc_out), 32'd104);
    checkOutput("fwd_target_count", 32'(instr_count), 32'd23);
    stepEdges(1);
    checkOutput("fwd_next_pc", 32'(pc_out), 32'd108);
    checkOutput("fwd_next_count", 32'(instr_count), 32'd24);

    // ---------------- Backward branch at pc 60, imm FFA -> 48 ----------------
    resetDut();
    stepEdges(16);
    checkOutput("bwd_pre_pc_out", 32'(pc_out), 32'd60);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'hFFA);
    stepEdges(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("bwd_address", 32'(address), 32'd48);
    stepEdges(2);
    checkOutput("bwd_target_valid", 32'(instr_valid), 32'd1);
    checkOutput("bwd_target_pc", 32'(pc_out), 32'd48);

    // ---------------- Wrapping branch at pc 4, imm FFC -> 252 ----------------
    resetDut();
    stepEdges(2);
    checkOutput("wrap_pre_pc_out", 32'(pc_out), 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'hFFC);
    stepEdges(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("wrap_address", 32'(address), 32'd252);
    stepEdges(1);
    checkOutput("wrap_hold_address", 32'(address), 32'd252);
    checkOutput("wrap_halted_lag", 32'(halted), 32'd0);
    stepEdges(1);
    checkOutput("wrap_target_pc", 32'(pc_out), 32'd252);
    checkOutput("wrap_target_valid", 32'(instr_valid), 32'd1);
    checkOutput("wrap_halted", 32'(halted), 32'd1);
    stepEdges(1);
    checkOutput("wrap_drained", 32'(instr_valid), 32'd0);

    // ---------------- Misaligned branch at pc 40 with halt ----------------
    resetDut();
    stepEdges(11);
    checkOutput("mis_pre_pc_out", 32'(pc_out), 32'd40);
    checkOutput("mis_pre_address", 32'(address), 32'd48);
    applyStimulus(1'b0, 1'b1, 1'b1, 12'd1);
    stepEdges(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("mis_err", 32'(err_misalign), 32'd1);
    checkOutput("mis_valid", 32'(instr_valid), 32'd0);
    checkOutput("mis_address", 32'(address), 32'd48);
    checkOutput("mis_halted_lag", 32'(halted), 32'd0);
    checkOutput("mis_count", 32'(instr_count), 32'd10);
    stepEdges(1);
    checkOutput("mis_halted", 32'(halted), 32'd1);
    checkOutput("mis_valid2", 32'(instr_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'd4);
    stepEdges(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
    checkOutput("mis_valid_late", 32'(instr_valid), 32'd0);
    checkOutput("mis_address_late", 32'(address), 32'd48);
    checkOutput("mis_count_late", 32'(instr_count), 32'd10);
    checkOutput("mis_err_sticky", 32'(err_misalign), 32'd1);

    // ---------------- Asynchronous reset mid-operation ----------------
    rst_n = 1'b0;
    #1;
    checkOutput("async_err", 32'(err_misalign), 32'd0);
    checkOutput("async_halted", 32'(halted), 32'd0);
    checkOutput("async_address", 32'(address), 32'd4);
    checkOutput("async_count", 32'(instr_count), 32'd0);

    // ---------------- End of program ----------------
    resetDut();
    stepEdges(62);
    checkOutput("end_e62_address", 32'(address), 32'd252);
    stepEdges(1);
    checkOutput("end_e63_address", 32'(address), 32'd252);
    checkOutput("end_e63_pc_out", 32'(pc_out), 32'd248);
    checkOutput("end_e63_halted", 32'(halted), 32'd0);
    stepEdges(1);
    checkOutput("end_e64_pc_out", 32'(pc_out), 32'd252);
    checkOutput("end_e64_valid", 32'(instr_valid), 32'd1);
    checkOutput("end_e64_halted", 32'(halted), 32'd1);
    stepEdges(1);
    checkOutput("end_e65_valid", 32'(instr_valid), 32'd0);
    checkOutput("end_e65_count", 32'(instr_count), 32'd63);
    stepEdges(2);
    checkOutput("end_e67_valid", 32'(instr_valid), 32'd0);
    checkOutput("end_e67_count", 32'(instr_count), 32'd63);
    checkOutput("end_e67_address", 32'(address), 32'd252);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
